// File: rtl/rv32im_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rv32im_mem_arbiter
//
// Shares one memory port between the instruction fetch unit (read-only) and
// the load/store unit (read/write with byte mask). The granted request is
// latched and presented to memory until it signals ready, or until the
// transaction has been busy for TIMEOUT_CYCLES cycles and is aborted.
// Completion is reported with a one-cycle ack pulse to the owner, together
// with err_o when the transaction was aborted.
//
// Ports:
//   clk_i, rst_i             clock (rising edge), async active-high reset
//   ifu_req_i/ifu_addr_i     IFU read request and word address
//   ifu_ack_o/ifu_rdata_o    IFU completion pulse and read data
//   lsu_req_i/lsu_we_i       LSU request, 1 = store / 0 = load
//   lsu_addr_i/lsu_wmask_i   LSU address and store byte mask
//   lsu_wdata_i              LSU store data (lane-aligned)
//   lsu_ack_o/lsu_rdata_o    LSU completion pulse and raw read word
//   err_o                    pulses with ack when the transaction timed out
//   mem_req_o .. mem_wdata_o memory request and latched request fields
//   mem_ready_i/mem_rdata_i  memory completion and read data
// ---------------------------------------------------------------------------
module rv32im_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_CNT_WIDTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  ifu_req_i,
    input  logic [ADDR_WIDTH-1:0] ifu_addr_i,
    output logic                  ifu_ack_o,
    output logic [DATA_WIDTH-1:0] ifu_rdata_o,

    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [3:0]            lsu_wmask_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_ack_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,

    output logic                  err_o,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_wmask_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_t;

    localparam bit                    TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_CNT_WIDTH-1:0] TO_LAST = TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                  state_q,      state_d;
    owner_t                  owner_q,      owner_d;
    owner_t                  last_grant_q, last_grant_d;
    logic [TO_CNT_WIDTH-1:0] cnt_q,        cnt_d;
    logic                    we_q,         we_d;
    logic [ADDR_WIDTH-1:0]   addr_q,       addr_d;
    logic [3:0]              wmask_q,      wmask_d;
    logic [DATA_WIDTH-1:0]   wdata_q,      wdata_d;
    logic [DATA_WIDTH-1:0]   ifu_rdata_q,  ifu_rdata_d;
    logic [DATA_WIDTH-1:0]   lsu_rdata_q,  lsu_rdata_d;
    logic                    err_q,        err_d;

    logic grant_lsu;
    logic timeout_hit;

    // Under contention the requester that did not win last time is served.
    assign grant_lsu   = lsu_req_i && (!ifu_req_i || (last_grant_q == OWN_IFU));
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wmask_d      = wmask_q;
        wdata_d      = wdata_q;
        ifu_rdata_d  = ifu_rdata_q;
        lsu_rdata_d  = lsu_rdata_q;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (ifu_req_i || lsu_req_i) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                    if (grant_lsu) begin
                        owner_d = OWN_LSU;
                        addr_d  = lsu_addr_i;
                        we_d    = lsu_we_i;
                        wmask_d = lsu_we_i ? lsu_wmask_i : 4'b0000;
                        wdata_d = lsu_wdata_i;
                    end else begin
                        owner_d = OWN_IFU;
                        addr_d  = ifu_addr_i;
                        we_d    = 1'b0;
                        wmask_d = 4'b0000;
                        wdata_d = '0;
                    end
                end
            end

            S_BUSY: begin
                // Ready takes priority over a timeout firing in the same cycle.
                if (mem_ready_i) begin
                    state_d = S_RESP;
                    err_d   = 1'b0;
                    if (owner_q == OWN_IFU) begin
                        ifu_rdata_d = mem_rdata_i;
                    end else if (!we_q) begin
                        lsu_rdata_d = mem_rdata_i;
                    end
                end else begin
                    // Saturate rather than wrap, also when the timeout is disabled.
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (timeout_hit) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        // Store completions never disturb the LSU read word.
                        if (owner_q == OWN_IFU) begin
                            ifu_rdata_d = '0;
                        end else if (!we_q) begin
                            lsu_rdata_d = '0;
                        end
                    end
                end
            end

            S_RESP: begin
                state_d      = S_IDLE;
                last_grant_d = owner_q;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_IFU;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wmask_q      <= 4'b0000;
            wdata_q      <= '0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wmask_q      <= wmask_d;
            wdata_q      <= wdata_d;
            ifu_rdata_q  <= ifu_rdata_d;
            lsu_rdata_q  <= lsu_rdata_d;
            err_q        <= err_d;
        end
    end

    // Outputs decode directly from registered state so a reset drops the
    // memory request immediately.
    assign mem_req_o   = (state_q == S_BUSY);
    assign mem_we_o    = (state_q == S_BUSY) && we_q;
    assign mem_wmask_o = (state_q == S_BUSY) ? wmask_q : 4'b0000;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign ifu_ack_o   = (state_q == S_RESP) && (owner_q == OWN_IFU);
    assign lsu_ack_o   = (state_q == S_RESP) && (owner_q == OWN_LSU);
    assign err_o       = (state_q == S_RESP) && err_q;
    assign ifu_rdata_o = ifu_rdata_q;
    assign lsu_rdata_o = lsu_rdata_q;

endmodule

// File: tb/tb_rv32im_mem_arbiter.sv
module tb_rv32im_mem_arbiter;

    localparam int TO = 4;

    logic        clk_i;
    logic        rst_i;
    logic        ifu_req_i;
    logic [31:0] ifu_addr_i;
    logic        ifu_ack_o;
    logic [31:0] ifu_rdata_o;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [31:0] lsu_addr_i;
    logic [3:0]  lsu_wmask_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_ack_o;
    logic [31:0] lsu_rdata_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_wmask_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;

    rv32im_mem_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TO),
        .TO_CNT_WIDTH  (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ifu_req_i  (ifu_req_i),
        .ifu_addr_i (ifu_addr_i),
        .ifu_ack_o  (ifu_ack_o),
        .ifu_rdata_o(ifu_rdata_o),
        .lsu_req_i  (lsu_req_i),
        .lsu_we_i   (lsu_we_i),
        .lsu_addr_i (lsu_addr_i),
        .lsu_wmask_i(lsu_wmask_i),
        .lsu_wdata_i(lsu_wdata_i),
        .lsu_ack_o  (lsu_ack_o),
        .lsu_rdata_o(lsu_rdata_o),
        .err_o      (err_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wmask_o(mem_wmask_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i),
        .mem_rdata_i(mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_lsu;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    // Memory model: ready after mem_delay further BUSY cycles (-1 = never).
    int          mem_delay = 0;
    bit          use_addr  = 1'b0;
    logic [31:0] rd_base   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    initial begin
        int bcnt;
        bcnt        = 0;
        mem_ready_i = 1'b0;
        mem_rdata_i = 32'hBAD0BAD0;
        forever begin
            @(negedge clk_i);
            if (mem_req_o) begin
                mem_ready_i = (mem_delay >= 0) && (bcnt == mem_delay);
                mem_rdata_i = mem_ready_i ? (use_addr ? (rd_base | mem_addr_o) : rd_base)
                                          : 32'hBAD0BAD0;
                bcnt++;
            end else begin
                mem_ready_i = 1'b0;
                mem_rdata_i = 32'hBAD0BAD0;
                bcnt        = 0;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            check("ack_overlap", {31'b0, ifu_ack_o & lsu_ack_o}, 32'd0);
            check("stray_err", {31'b0, err_o & ~(ifu_ack_o | lsu_ack_o)}, 32'd0);
            if (ifu_ack_o || lsu_ack_o) begin
                check("ack_expected", {31'b0, sb.size() > 0}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("ack_owner", {31'b0, lsu_ack_o}, {31'b0, e.is_lsu});
                    check("ack_err", {31'b0, err_o}, {31'b0, e.err});
                    check("ack_rdata", lsu_ack_o ? lsu_rdata_o : ifu_rdata_o, e.rdata);
                    check("ack_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic push(input bit is_lsu, input bit err, input logic [31:0] rdata, input int c);
        exp_t e;
        e.is_lsu = is_lsu;
        e.err    = err;
        e.rdata  = rdata;
        e.cyc    = c;
        sb.push_back(e);
    endtask

    // Single transaction, entered and left on a negedge in IDLE.
    task automatic run_txn(input bit is_lsu, input bit we, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [31:0] wdata,
                           input int delay, input logic [31:0] rd,
                           input bit exp_err, input logic [31:0] exp_rdata);
        int  busy;
        int  nbusy;
        bit  got;
        bit  bad;
        bit  exp_we;
        mem_delay = delay;
        use_addr  = 1'b0;
        rd_base   = rd;
        exp_we    = is_lsu && we;
        busy      = (delay < 0 || delay >= TO) ? TO : delay + 1;
        if (is_lsu) begin
            lsu_req_i   = 1'b1;
            lsu_we_i    = we;
            lsu_addr_i  = addr;
            lsu_wmask_i = mask;
            lsu_wdata_i = wdata;
        end else begin
            ifu_req_i  = 1'b1;
            ifu_addr_i = addr;
        end
        push(is_lsu, exp_err, exp_rdata, cyc + 1 + busy);
        nbusy = 0;
        got   = 1'b0;
        bad   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_i);
            if (mem_req_o) begin
                nbusy++;
                if (mem_addr_o !== addr || mem_we_o !== exp_we ||
                    mem_wmask_o !== (exp_we ? mask : 4'b0000) ||
                    (exp_we && mem_wdata_o !== wdata))
                    bad = 1'b1;
            end
            if (is_lsu ? lsu_ack_o : ifu_ack_o) got = 1'b1;
        end
        ifu_req_i = 1'b0;
        lsu_req_i = 1'b0;
        check("ack_seen", {31'b0, got}, 32'd1);
        check("busy_fields", {31'b0, bad}, 32'd0);
        check("busy_len", nbusy, busy);
    endtask

    initial begin
        int k;
        rst_i       = 1'b1;
        ifu_req_i   = 1'b0;
        ifu_addr_i  = '0;
        lsu_req_i   = 1'b0;
        lsu_we_i    = 1'b0;
        lsu_addr_i  = '0;
        lsu_wmask_i = '0;
        lsu_wdata_i = '0;
        repeat (3) @(negedge clk_i);

        check("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
        check("rst_mem_wmask", {28'b0, mem_wmask_o}, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_wdata", mem_wdata_o, 32'd0);
        check("rst_rdata", ifu_rdata_o | lsu_rdata_o, 32'd0);
        check("rst_ack_err", {29'b0, ifu_ack_o, lsu_ack_o, err_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Contention from reset: LSU, IFU, LSU, IFU, acks 3 cycles apart.
        mem_delay  = 0;
        use_addr   = 1'b1;
        rd_base    = '0;
        ifu_req_i  = 1'b1;
        ifu_addr_i = 32'h300;
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_addr_i = 32'h400;
        k = cyc;
        push(1'b1, 1'b0, 32'h400, k + 2);
        push(1'b0, 1'b0, 32'h300, k + 5);
        push(1'b1, 1'b0, 32'h400, k + 8);
        push(1'b0, 1'b0, 32'h300, k + 11);
        repeat (11) @(negedge clk_i);
        ifu_req_i = 1'b0;
        lsu_req_i = 1'b0;
        @(negedge clk_i);

        // IFU read, ready in 4th BUSY cycle (also the last cycle before timeout).
        run_txn(1'b0, 1'b0, 32'h100, 4'b0000, 32'h0, 3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
        @(negedge clk_i);

        // IFU holds req across ack with a new address.
        mem_delay  = 0;
        use_addr   = 1'b1;
        rd_base    = '0;
        ifu_req_i  = 1'b1;
        ifu_addr_i = 32'h100;
        k = cyc;
        push(1'b0, 1'b0, 32'h100, k + 2);
        push(1'b0, 1'b0, 32'h104, k + 5);
        repeat (2) @(negedge clk_i);
        ifu_addr_i = 32'h104;
        repeat (2) @(negedge clk_i);
        check("b2b_req", {31'b0, mem_req_o}, 32'd1);
        check("b2b_addr", mem_addr_o, 32'h104);
        @(negedge clk_i);
        ifu_req_i = 1'b0;
        @(negedge clk_i);

        // LSU SB store; LSU read word must hold the earlier load value.
        run_txn(1'b1, 1'b1, 32'h203, 4'b1000, 32'hAB000000, 0, 32'h55555555, 1'b0, 32'h400);
        @(negedge clk_i);

        // LSU load that never completes, then one ready in the 4th BUSY cycle.
        run_txn(1'b1, 1'b0, 32'h600, 4'b1111, 32'h0, -1, 32'h0, 1'b1, 32'h0);
        @(negedge clk_i);
        run_txn(1'b1, 1'b0, 32'h604, 4'b1111, 32'h0, 3, 32'h12345678, 1'b0, 32'h12345678);
        @(negedge clk_i);

        // Reset in the 2nd BUSY cycle of an IFU read: no ack, last_grant back to IFU.
        mem_delay  = -1;
        ifu_req_i  = 1'b1;
        ifu_addr_i = 32'h500;
        repeat (2) @(negedge clk_i);
        check("pre_rst_req", {31'b0, mem_req_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("async_rst_req", {31'b0, mem_req_o}, 32'd0);
        ifu_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // First contention after reset goes to LSU.
        mem_delay  = 0;
        use_addr   = 1'b1;
        rd_base    = '0;
        ifu_req_i  = 1'b1;
        ifu_addr_i = 32'h800;
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_addr_i = 32'h700;
        k = cyc;
        push(1'b1, 1'b0, 32'h700, k + 2);
        push(1'b0, 1'b0, 32'h800, k + 5);
        repeat (2) @(negedge clk_i);
        lsu_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        ifu_req_i = 1'b0;
        repeat (4) @(negedge clk_i);

        check("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
